// File: rtl/mem_region_router.sv
// mem_region_router: decodes one CPU memory request against N_TGT programmable
// base/mask regions and forwards it to the first matching target over a
// req/wait/ack handshake. Unmapped, ambiguous (read+write) and timed-out
// requests complete with req_err=1.
// Optional build macro: SEGMENT_MIRROR_EN -- when defined, the top three
// address bits are cleared before decode, so KUSEG/KSEG0/KSEG1 mirrors
// reach the same target.
module mem_region_router #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_TGT = 4,
  parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE =
    {32'h1F80_1000, 32'h1F80_0000, 32'h0000_0000, 32'h1FC0_0000},
  parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK =
    {32'hFFFF_F000, 32'hFFFF_FC00, 32'hFFE0_0000, 32'hFFF8_0000},
  parameter int TIMEOUT = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [DATA_W/8-1:0]     req_be,
  input  logic                    req_ren,
  input  logic                    req_wen,
  output logic                    req_ack,
  output logic                    req_err,
  output logic [DATA_W-1:0]       req_rdata,
  output logic [4:0]              state,
  output logic [N_TGT-1:0]        tgt_req,
  output logic                    tgt_we,
  output logic [ADDR_W-1:0]       tgt_addr,
  output logic [DATA_W-1:0]       tgt_wdata,
  output logic [DATA_W/8-1:0]     tgt_be,
  input  logic [N_TGT*DATA_W-1:0] tgt_rdata,
  input  logic [N_TGT-1:0]        tgt_wait,
  input  logic [N_TGT-1:0]        tgt_ack
);

  localparam int BE_W = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ISSUE = 5'b00010,
    S_RESP  = 5'b00100,
    S_DONE  = 5'b01000,
    S_ERR   = 5'b10000
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] decode_addr;
  logic [N_TGT-1:0]  hit;
  logic [N_TGT-1:0]  hit_sel;
  logic              mapped;

  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [BE_W-1:0]   be_reg;
  logic [N_TGT-1:0]  sel_reg;
  logic              we_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ack_reg;
  logic              err_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [DATA_W-1:0] rdata_sel;
  logic [ADDR_W-1:0] mask_sel;
  logic              wait_sel;
  logic              ack_sel;
  logic              timeout_hit;
  logic [N_TGT-1:0]  tgt_req_c;

`ifdef SEGMENT_MIRROR_EN
  // Segment bits are dropped so all three CPU segments alias one region.
  assign decode_addr = {3'b000, req_addr[ADDR_W-4:0]};
`else
  assign decode_addr = req_addr;
`endif

  // Region match per target.
  generate
    for (genvar gi = 0; gi < N_TGT; gi++) begin : g_hit
      assign hit[gi] = ((decode_addr & TGT_MASK[gi*ADDR_W +: ADDR_W])
                        == TGT_BASE[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  // Lowest-index hit wins: isolate the least significant set bit.
  assign hit_sel = hit & (~hit + N_TGT'(1));
  assign mapped  = |hit;

  // Selected target's read data and region mask, from the latched one-hot select.
  always_comb begin
    rdata_sel = '0;
    mask_sel  = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (sel_reg[i]) begin
        rdata_sel = rdata_sel | tgt_rdata[i*DATA_W +: DATA_W];
        mask_sel  = mask_sel | TGT_MASK[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign wait_sel    = |(tgt_wait & sel_reg);
  assign ack_sel     = |(tgt_ack & sel_reg);
  assign timeout_hit = (cnt_reg == CNT_LAST);

  // Next-state decode and the state-qualified target strobe.
  always_comb begin
    state_next = state_reg;
    tgt_req_c  = '0;
    case (state_reg)
      S_IDLE: begin
        if (req_ren && req_wen) begin
          state_next = S_ERR;
        end else if (req_ren || req_wen) begin
          state_next = mapped ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE: begin
        tgt_req_c = sel_reg;
        if (timeout_hit) begin
          state_next = S_ERR;
        end else if (!wait_sel) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        // An ack arriving on the timeout cycle still completes normally.
        if (ack_sel) begin
          state_next = S_DONE;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      S_ERR: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        if (!req_ren && !req_wen) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the request when it is accepted for a mapped target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
    end else if (state_reg == S_IDLE && state_next == S_ISSUE) begin
      addr_reg  <= decode_addr;
      wdata_reg <= req_wdata;
      be_reg    <= req_be;
      sel_reg   <= hit_sel;
      we_reg    <= req_wen;
    end
  end

  // Cycle counter covering the ISSUE+RESP window; idle elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == S_ISSUE || state_reg == S_RESP) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else begin
      cnt_reg <= '0;
    end
  end

  // Response registers: ack/err rise on entry to DONE, fall on leaving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        S_ISSUE: begin
          if (timeout_hit) begin
            rdata_reg <= '0;
          end
        end
        S_RESP: begin
          if (ack_sel) begin
            ack_reg <= 1'b1;
            if (!we_reg) begin
              rdata_reg <= rdata_sel;
            end
          end else if (timeout_hit) begin
            rdata_reg <= '0;
          end
        end
        S_ERR: begin
          ack_reg <= 1'b1;
          err_reg <= 1'b1;
        end
        S_DONE: begin
          if (!req_ren && !req_wen) begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ack   = ack_reg;
  assign req_err   = err_reg;
  assign req_rdata = rdata_reg;
  assign state     = state_reg;
  assign tgt_req   = tgt_req_c;
  assign tgt_we    = we_reg;
  assign tgt_addr  = addr_reg & ~mask_sel;
  assign tgt_wdata = wdata_reg;
  assign tgt_be    = be_reg;

endmodule

// File: tb/tb_mem_region_router.sv
// Testbench for mem_region_router: directed transactions with a scoreboard.
// Stimulus pushes the hand-computed expectation for each request; a monitor
// measures the DUT's behaviour and compares when req_ack appears. A second
// instance with overlapping regions checks lowest-index priority.
module tb_mem_region_router;

  typedef struct {
    string       name;
    logic [3:0]  exp_req;
    int          exp_strobe;
    int          exp_lat;
    logic        exp_err;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic        chk_lat;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        chk_ovl;
    logic [3:0]  exp_ovl;
  } item_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [3:0]   req_be = '0;
  logic         req_ren = 1'b0;
  logic         req_wen = 1'b0;
  logic         req_ack, req_err;
  logic [31:0]  req_rdata;
  logic [4:0]   state;
  logic [3:0]   tgt_req;
  logic         tgt_we;
  logic [31:0]  tgt_addr, tgt_wdata;
  logic [3:0]   tgt_be;
  logic [127:0] tgt_rdata = '0;
  logic [3:0]   tgt_wait = '0;
  logic [3:0]   tgt_ack = '0;

  logic         o_ack, o_err, o_we;
  logic [31:0]  o_rdata, o_addr, o_wdata;
  logic [4:0]   o_state;
  logic [3:0]   o_req, o_be;

  item_t sb[$];
  int checks = 0;
  int errors = 0;
  int cfg_tgt = 0;
  int cfg_wait = 0;

  mem_region_router u_dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .req_ren(req_ren), .req_wen(req_wen),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .state(state), .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_addr(tgt_addr),
    .tgt_wdata(tgt_wdata), .tgt_be(tgt_be), .tgt_rdata(tgt_rdata),
    .tgt_wait(tgt_wait), .tgt_ack(tgt_ack)
  );

  // Target 1 widened to overlap target 0 (both cover 0x1FC0_0000..).
  mem_region_router #(
    .TGT_BASE({32'h1F80_1000, 32'h1F80_0000, 32'h1FC0_0000, 32'h1FC0_0000}),
    .TGT_MASK({32'hFFFF_F000, 32'hFFFF_FC00, 32'hFFC0_0000, 32'hFFF8_0000})
  ) u_ovl (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .req_ren(req_ren), .req_wen(req_wen),
    .req_ack(o_ack), .req_err(o_err), .req_rdata(o_rdata),
    .state(o_state), .tgt_req(o_req), .tgt_we(o_we), .tgt_addr(o_addr),
    .tgt_wdata(o_wdata), .tgt_be(o_be), .tgt_rdata(tgt_rdata),
    .tgt_wait(tgt_wait), .tgt_ack(tgt_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
    end
  endtask

  function automatic item_t mk(input string nm, input logic [3:0] rq,
      input int strb, input int lat, input logic er, input logic crd,
      input logic [31:0] rd, input logic cl, input logic [31:0] ad,
      input logic we, input logic [3:0] be, input logic [31:0] wd,
      input logic co, input logic [3:0] ov);
    item_t it;
    it.name = nm; it.exp_req = rq; it.exp_strobe = strb; it.exp_lat = lat;
    it.exp_err = er; it.chk_rdata = crd; it.exp_rdata = rd; it.chk_lat = cl;
    it.exp_addr = ad; it.exp_we = we; it.exp_be = be; it.exp_wdata = wd;
    it.chk_ovl = co; it.exp_ovl = ov;
    return it;
  endfunction

  // Target model: the configured target stalls its first cfg_wait strobe cycles.
  initial begin
    int seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (tgt_req[cfg_tgt]) begin
        if (seen < cfg_wait) begin
          tgt_wait = 4'b0001 << cfg_tgt;
          seen++;
        end else begin
          tgt_wait = '0;
        end
      end else begin
        tgt_wait = '0;
        seen = 0;
      end
    end
  end

  // Monitor: measures each transaction and checks it against the scoreboard.
  initial begin
    bit in_txn, hold;
    int lat, strobe_n;
    logic [3:0] first_req, first_ovl;
    item_t cur;
    in_txn = 0; hold = 0; lat = 0; strobe_n = 0;
    first_req = '0; first_ovl = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_txn = 0;
        hold = 0;
      end else if (hold) begin
        if (req_ren || req_wen) begin
          check(cur.name, "held_ack", {31'b0, req_ack}, 32'd1);
          check(cur.name, "held_err", {31'b0, req_err}, {31'b0, cur.exp_err});
          check(cur.name, "held_state", {27'b0, state}, 32'h08);
          if (cur.chk_rdata)
            check(cur.name, "held_rdata", req_rdata, cur.exp_rdata);
        end else begin
          check(cur.name, "release_ack_err", {30'b0, req_ack, req_err}, 32'd0);
          check(cur.name, "release_state", {27'b0, state}, 32'h01);
          hold = 0;
        end
      end else begin
        if (!in_txn && (req_ren || req_wen)) begin
          in_txn = 1; lat = 0; strobe_n = 0; first_req = '0; first_ovl = '0;
        end
        if (in_txn) begin
          lat++;
          if (tgt_req != 0) begin
            if (strobe_n == 0) first_req = tgt_req;
            strobe_n++;
          end
          if (o_req != 0 && first_ovl == 0) first_ovl = o_req;
          if (req_ack) begin
            in_txn = 0;
            if (sb.size() == 0) begin
              check("monitor", "sb_nonempty", 32'd0, 32'd1);
            end else begin
              cur = sb.pop_front();
              hold = 1;
              $display("txn %s lat=%0d strobes=%0d req=%b err=%b rdata=%h addr=%h",
                       cur.name, lat, strobe_n, first_req, req_err, req_rdata, tgt_addr);
              check(cur.name, "latency", lat, cur.exp_lat);
              check(cur.name, "strobes", strobe_n, cur.exp_strobe);
              check(cur.name, "tgt_req", {28'b0, first_req}, {28'b0, cur.exp_req});
              check(cur.name, "err", {31'b0, req_err}, {31'b0, cur.exp_err});
              if (cur.chk_rdata)
                check(cur.name, "rdata", req_rdata, cur.exp_rdata);
              if (cur.chk_lat) begin
                check(cur.name, "tgt_addr", tgt_addr, cur.exp_addr);
                check(cur.name, "tgt_we", {31'b0, tgt_we}, {31'b0, cur.exp_we});
                check(cur.name, "tgt_be", {28'b0, tgt_be}, {28'b0, cur.exp_be});
                check(cur.name, "tgt_wdata", tgt_wdata, cur.exp_wdata);
              end
              if (cur.chk_ovl)
                check(cur.name, "ovl_tgt_req", {28'b0, first_ovl}, {28'b0, cur.exp_ovl});
            end
          end
        end else if (req_ack) begin
          check("monitor", "unexpected_ack", {31'b0, req_ack}, 32'd0);
        end
      end
    end
  end

  // One request: inputs are scrambled after acceptance to prove they are latched.
  task automatic run_txn(input item_t it, input logic ren, input logic wen,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
      input int tgt, input int wt, input logic [3:0] ack, input logic [3:0] late_ack);
    int n;
    @(negedge clk);
    cfg_tgt = tgt; cfg_wait = wt; tgt_ack = ack;
    req_addr = addr; req_wdata = wdata; req_be = be;
    sb.push_back(it);
    req_ren = ren; req_wen = wen;
    @(negedge clk);
    req_addr = 32'h1F00_0000; req_wdata = ~wdata; req_be = ~be;
    n = 0;
    while (req_ack !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(it.name, "ack_within_bound", {31'b0, req_ack}, 32'd1);
    tgt_ack = late_ack;
    repeat (3) @(negedge clk);
    req_ren = 1'b0; req_wen = 1'b0; tgt_ack = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, "state", {27'b0, state}, 32'h01);
    check(nm, "tgt_req", {28'b0, tgt_req}, 32'd0);
    check(nm, "ack_err", {30'b0, req_ack, req_err}, 32'd0);
    check(nm, "rdata", req_rdata, 32'd0);
    check(nm, "tgt_addr", tgt_addr, 32'd0);
    check(nm, "tgt_wdata", tgt_wdata, 32'd0);
    check(nm, "tgt_we_be", {27'b0, tgt_we, tgt_be}, 32'd0);
  endtask

  // Watchdog so a wedged run still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tgt_rdata[0 +: 32]  = 32'hDEAD_BEEF;
    tgt_rdata[32 +: 32] = 32'h1111_0001;
    tgt_rdata[64 +: 32] = 32'h2222_0002;
    tgt_rdata[96 +: 32] = 32'h3333_0003;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // BIOS read, zero wait, ack in first RESP cycle; overlap copy picks target 0.
    run_txn(mk("rd_bios", 4'b0001, 1, 3, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1,
               32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b1, 4'b0001),
            1'b1, 1'b0, 32'h1FC0_0010, 32'h0, 4'hF, 0, 0, 4'b0001, 4'b0000);
    // SDRAM write, 3 wait cycles; ack held high from the start is ignored in ISSUE.
    run_txn(mk("wr_sdram", 4'b0010, 4, 6, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1,
               32'h0000_0100, 1'b1, 4'b0011, 32'hA5A5_1234, 1'b0, 4'b0),
            1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_1234, 4'b0011, 1, 3, 4'b0010, 4'b0000);
    // Hardware-register read with every target acking.
    run_txn(mk("rd_hwreg", 4'b1000, 1, 3, 1'b0, 1'b1, 32'h3333_0003, 1'b1,
               32'h0000_0014, 1'b0, 4'hF, 32'h0000_00C3, 1'b1, 4'b1000),
            1'b1, 1'b0, 32'h1F80_1014, 32'h0000_00C3, 4'hF, 3, 0, 4'b1111, 4'b0000);
    // Scratch-pad read.
    run_txn(mk("rd_scratch", 4'b0100, 1, 3, 1'b0, 1'b1, 32'h2222_0002, 1'b1,
               32'h0000_0004, 1'b0, 4'b1010, 32'h0, 1'b1, 4'b0100),
            1'b1, 1'b0, 32'h1F80_0004, 32'h0, 4'b1010, 2, 0, 4'b0100, 4'b0000);
    // Unmapped read: error two cycles later, no strobe.
    run_txn(mk("rd_unmapped", 4'b0000, 0, 2, 1'b1, 1'b0, 32'h0, 1'b0,
               32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'b0000),
            1'b1, 1'b0, 32'h1F00_0000, 32'h0, 4'hF, 0, 0, 4'b1111, 4'b0000);
    // Read and write together on a mapped address: error.
    run_txn(mk("rw_both", 4'b0000, 0, 2, 1'b1, 1'b0, 32'h0, 1'b0,
               32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'b0000),
            1'b1, 1'b1, 32'h1FC0_0010, 32'h0, 4'hF, 0, 0, 4'b0001, 4'b0000);

    // Reset asserted while waiting in RESP.
    @(negedge clk);
    cfg_tgt = 0; cfg_wait = 0; tgt_ack = '0;
    req_addr = 32'h1FC0_0010; req_be = 4'hF; req_ren = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst", "pre_state", {27'b0, state}, 32'h04);
    req_ren = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Normal read after reset.
    tgt_rdata[0 +: 32] = 32'hCAFE_F00D;
    run_txn(mk("rd_after_rst", 4'b0001, 1, 3, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1,
               32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b1, 4'b0001),
            1'b1, 1'b0, 32'h1FC0_0010, 32'h0, 4'hF, 0, 0, 4'b0001, 4'b0000);
    // Target 1 never acks (others do): 100 ISSUE+RESP cycles, one ERR cycle,
    // then DONE -> ack visible 102 cycles after the request is sampled.
    // A late ack from target 1 during DONE must change nothing.
    run_txn(mk("rd_timeout", 4'b0010, 1, 102, 1'b1, 1'b1, 32'h0, 1'b1,
               32'h0000_0200, 1'b0, 4'hF, 32'h0, 1'b0, 4'b0),
            1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, 0, 4'b1101, 4'b0010);

    check("end", "sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
